// File: rtl/rst_seq_pkg.sv
// Shared types and default delays for the power-on reset sequencer.
package rst_seq_pkg;

    localparam int DEF_PERIPH_DLY = 1024;
    localparam int DEF_CTRL_DLY   = 256;
    localparam int DEF_READY_TO   = 65536;
    localparam int DEF_WDOG_TO    = 50000;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_WAIT_READY,
        ST_CTRL_DLY,
        ST_RUN,
        ST_FAULT
    } seq_state_e;

    typedef enum logic [1:0] {
        FLT_NONE   = 2'd0,
        FLT_RDY_TO = 2'd1,
        FLT_EXT    = 2'd2,
        FLT_WDOG   = 2'd3
    } flt_code_e;

    // A zero delay still takes one clock.
    function automatic int clamp1(input int d);
        return (d < 1) ? 1 : d;
    endfunction

    function automatic int tmr_width(input int a, input int b, input int c, input int d);
        int m;
        m = clamp1(a);
        if (clamp1(b) > m) m = clamp1(b);
        if (clamp1(c) > m) m = clamp1(c);
        if (clamp1(d) > m) m = clamp1(d);
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable down-counter: counts to zero and stops; done while parked at zero.
module rst_seq_timer #(
    parameter int               WIDTH   = 17,
    parameter logic [WIDTH-1:0] RST_VAL = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             RST_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] value_o,
    output logic             done_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = (load_val_i == '0) ? ONE : load_val_i;
        end else if (value_q != '0) begin
            value_d = value_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            value_q <= RST_VAL;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;
    assign done_o  = (value_q == '0);

endmodule

// File: rtl/rst_sequencer.sv
// Power-on reset sequencer: peripheral reset, sensor ready wait, controller reset, run/fault.
// Define RST_SEQ_WDOG_EN to add the RUN-state watchdog on wdog_kick.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int PERIPH_DLY = DEF_PERIPH_DLY,
    parameter int CTRL_DLY   = DEF_CTRL_DLY,
    parameter int READY_TO   = DEF_READY_TO,
    parameter int WDOG_TO    = DEF_WDOG_TO
) (
    input  logic       clk,
    input  logic       RST_n,
    input  logic       sensor_rdy,
    input  logic       fault_in,
    input  logic       clr_fault,
    input  logic       wdog_kick,
    output logic       periph_rst_n,
    output logic       ctrl_rst_n,
    output logic       pwr_en,
    output logic [1:0] fault_code
);

    localparam int TW = tmr_width(PERIPH_DLY, CTRL_DLY, READY_TO, WDOG_TO);
    localparam logic [TW-1:0] ONE       = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] PERIPH_LD = TW'(clamp1(PERIPH_DLY));
    localparam logic [TW-1:0] CTRL_LD   = TW'(clamp1(CTRL_DLY));
    localparam logic [TW-1:0] READY_LD  = TW'(clamp1(READY_TO));

    seq_state_e state_q, state_d;
    flt_code_e  fault_code_q, fault_code_d;
    logic       periph_rst_n_q;
    logic       ctrl_rst_n_q;
    logic       pwr_en_q;

    logic          seq_load;
    logic [TW-1:0] seq_load_val;
    logic [TW-1:0] seq_value;
    logic          seq_done;
    logic          seq_expired;

    rst_seq_timer #(
        .WIDTH   (TW),
        .RST_VAL (PERIPH_LD)
    ) u_seq_timer (
        .clk        (clk),
        .RST_n      (RST_n),
        .load_i     (seq_load),
        .load_val_i (seq_load_val),
        .value_o    (seq_value),
        .done_o     (seq_done)
    );

    // Fire on the last count; a counter already run out also counts as expired.
    assign seq_expired = (seq_value == ONE) || seq_done;

`ifdef RST_SEQ_WDOG_EN
    localparam logic [TW-1:0] WDOG_LD = TW'(clamp1(WDOG_TO));

    logic          wdog_load;
    logic [TW-1:0] wdog_value;
    logic          wdog_done;
    logic          wdog_fault;

    rst_seq_timer #(
        .WIDTH   (TW),
        .RST_VAL (WDOG_LD)
    ) u_wdog_timer (
        .clk        (clk),
        .RST_n      (RST_n),
        .load_i     (wdog_load),
        .load_val_i (WDOG_LD),
        .value_o    (wdog_value),
        .done_o     (wdog_done)
    );

    // Reload on RUN entry and on every kick; a kick on the expiry cycle saves it.
    assign wdog_load  = (state_d == ST_RUN) && ((state_q != ST_RUN) || wdog_kick);
    assign wdog_fault = ((wdog_value == ONE) || wdog_done) && !wdog_kick;
`else
    logic wdog_kick_unused;
    assign wdog_kick_unused = wdog_kick;
`endif

    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        seq_load     = 1'b0;
        seq_load_val = READY_LD;
        case (state_q)
            ST_HOLD: begin
                if (seq_expired) begin
                    state_d  = ST_WAIT_READY;
                    seq_load = 1'b1;
                end
            end
            ST_WAIT_READY: begin
                if (fault_in) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FLT_EXT;
                end else if (sensor_rdy) begin
                    state_d      = ST_CTRL_DLY;
                    seq_load     = 1'b1;
                    seq_load_val = CTRL_LD;
                end else if (seq_expired) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FLT_RDY_TO;
                end
            end
            ST_CTRL_DLY: begin
                if (fault_in) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FLT_EXT;
                end else if (seq_expired) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fault_in) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FLT_EXT;
                end else if (!sensor_rdy) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FLT_RDY_TO;
                end
`ifdef RST_SEQ_WDOG_EN
                else if (wdog_fault) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FLT_WDOG;
                end
`endif
            end
            ST_FAULT: begin
                if (clr_fault && !fault_in) begin
                    state_d      = ST_WAIT_READY;
                    fault_code_d = FLT_NONE;
                    seq_load     = 1'b1;
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the transition edge.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_q        <= ST_HOLD;
            fault_code_q   <= FLT_NONE;
            periph_rst_n_q <= 1'b0;
            ctrl_rst_n_q   <= 1'b0;
            pwr_en_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            fault_code_q   <= fault_code_d;
            periph_rst_n_q <= (state_d != ST_HOLD);
            ctrl_rst_n_q   <= (state_d == ST_RUN);
            pwr_en_q       <= (state_q == ST_RUN) && (state_d == ST_RUN);
        end
    end

    assign periph_rst_n = periph_rst_n_q;
    assign ctrl_rst_n   = ctrl_rst_n_q;
    assign pwr_en       = pwr_en_q;
    assign fault_code   = fault_code_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer with short delays; expectations queued per clock edge.
module tb_rst_sequencer;

    logic       clk;
    logic       RST_n;
    logic       sensor_rdy;
    logic       fault_in;
    logic       clr_fault;
    logic       wdog_kick;
    logic       periph_rst_n;
    logic       ctrl_rst_n;
    logic       pwr_en;
    logic [1:0] fault_code;

    typedef struct packed {
        logic       p;
        logic       c;
        logic       w;
        logic [1:0] f;
    } obs_t;

    obs_t exp_q[$];
    obs_t got;
    obs_t exp_v;
    int   n_checks = 0;
    int   n_errors = 0;

    rst_sequencer #(
        .PERIPH_DLY (4),
        .CTRL_DLY   (2),
        .READY_TO   (10),
        .WDOG_TO    (8)
    ) dut (
        .clk          (clk),
        .RST_n        (RST_n),
        .sensor_rdy   (sensor_rdy),
        .fault_in     (fault_in),
        .clr_fault    (clr_fault),
        .wdog_kick    (wdog_kick),
        .periph_rst_n (periph_rst_n),
        .ctrl_rst_n   (ctrl_rst_n),
        .pwr_en       (pwr_en),
        .fault_code   (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation limit reached, got running required finished");
        $fatal(1);
    end

    function automatic obs_t mk(input logic p, input logic c, input logic w, input logic [1:0] f);
        return {p, c, w, f};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0));
            tick();
            got   = {periph_rst_n, ctrl_rst_n, pwr_en, fault_code};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL reset edge %0d: got %b required %b", i, got, exp_v);
            end else $display("[reset] edge %0d p/c/w/f=%b", i, got);
        end
    endtask

    task automatic test_nominal();
        RST_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            sensor_rdy = (i >= 7);
            exp_q.push_back(mk(i >= 4, i >= 9, i >= 10, 2'd0));
            tick();
            got   = {periph_rst_n, ctrl_rst_n, pwr_en, fault_code};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL nominal edge %0d: got %b required %b", i, got, exp_v);
            end else $display("[nominal] edge %0d p/c/w/f=%b", i, got);
        end
    endtask

    task automatic test_mid_reset();
        // Reset asserted mid-cycle must clear outputs before the next edge.
        RST_n = 1'b0;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0));
        #2;
        got   = {periph_rst_n, ctrl_rst_n, pwr_en, fault_code};
        exp_v = exp_q.pop_front();
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL mid_reset async: got %b required %b", got, exp_v);
        end else $display("[mid_reset] async p/c/w/f=%b", got);
        tick();
        tick();
        RST_n      = 1'b1;
        sensor_rdy = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            sensor_rdy = (i >= 7);
            exp_q.push_back(mk(i >= 4, i >= 9, i >= 10, 2'd0));
            tick();
            got   = {periph_rst_n, ctrl_rst_n, pwr_en, fault_code};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL mid_reset edge %0d: got %b required %b", i, got, exp_v);
            end else $display("[mid_reset] edge %0d p/c/w/f=%b", i, got);
        end
    endtask

    task automatic test_watchdog();
        // Kicks 7 apart, then one exactly on the expiry cycle, then silence.
        for (int i = 1; i <= 33; i++) begin
            wdog_kick = (i == 1) || (i == 8) || (i == 15) || (i == 23);
`ifdef RST_SEQ_WDOG_EN
            if (i >= 31) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'd3));
            else         exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 2'd0));
`else
            exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 2'd0));
`endif
            tick();
            got   = {periph_rst_n, ctrl_rst_n, pwr_en, fault_code};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL watchdog edge %0d: got %b required %b", i, got, exp_v);
            end else $display("[watchdog] edge %0d p/c/w/f=%b", i, got);
        end
        wdog_kick = 1'b0;
    endtask

    task automatic test_ready_timeout();
        RST_n      = 1'b0;
        sensor_rdy = 1'b0;
        tick();
        tick();
        RST_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            exp_q.push_back(mk(i >= 4, 1'b0, 1'b0, (i >= 14) ? 2'd1 : 2'd0));
            tick();
            got   = {periph_rst_n, ctrl_rst_n, pwr_en, fault_code};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL ready_timeout edge %0d: got %b required %b", i, got, exp_v);
            end else $display("[ready_timeout] edge %0d p/c/w/f=%b", i, got);
        end
    endtask

    task automatic test_boundary();
        // sensor_rdy arrives on the very edge the ready timer expires.
        RST_n      = 1'b0;
        sensor_rdy = 1'b0;
        tick();
        tick();
        RST_n = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            sensor_rdy = (i >= 14);
            exp_q.push_back(mk(i >= 4, i >= 16, i >= 17, 2'd0));
            tick();
            got   = {periph_rst_n, ctrl_rst_n, pwr_en, fault_code};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL boundary edge %0d: got %b required %b", i, got, exp_v);
            end else $display("[boundary] edge %0d p/c/w/f=%b", i, got);
        end
    endtask

    task automatic test_ext_fault();
        for (int i = 1; i <= 12; i++) begin
            fault_in   = (i >= 2) && (i <= 4);
            clr_fault  = (i == 4) || (i == 6) || (i == 10);
            sensor_rdy = (i == 1) || ((i >= 7) && (i <= 10));
            case (i)
                1:       exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 2'd0));
                2, 3, 4, 5: exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'd2));
                6, 7, 8: exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0));
                9:       exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 2'd0));
                10:      exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 2'd0));
                default: exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'd1));
            endcase
            tick();
            got   = {periph_rst_n, ctrl_rst_n, pwr_en, fault_code};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL ext_fault edge %0d: got %b required %b", i, got, exp_v);
            end else $display("[ext_fault] edge %0d p/c/w/f=%b", i, got);
        end
        fault_in  = 1'b0;
        clr_fault = 1'b0;
    endtask

    initial begin
        RST_n      = 1'b0;
        sensor_rdy = 1'b0;
        fault_in   = 1'b0;
        clr_fault  = 1'b0;
        wdog_kick  = 1'b0;
        test_reset();
        test_nominal();
        test_mid_reset();
        test_watchdog();
        test_ready_timeout();
        test_boundary();
        test_ext_fault();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 Parameters SHALL be:
- PERIPH_DLY, 1024: clocks from reset release to peripheral reset release.
- CTRL_DLY, 256: clocks from sensor ready to controller reset release.
- READY_TO, 65536: maximum clocks spent waiting for sensor_rdy.
- WDOG_TO, 50000: maximum clocks between wdog_kick pulses in RUN.
REQ-002 Ports SHALL be:
- clk  input  1  system clock; all logic on the rising edge.
- RST_n  input  1  reset: asynchronous, active-low; driven by the synchronized pushbutton reset.
- sensor_rdy  input  1  inertial sensor initialization complete (level).
- fault_in  input  1  external fault, e.g. overcurrent or battery low (level).
- clr_fault  input  1  single-cycle fault-clear request.
- wdog_kick  input  1  single-cycle watchdog kick from the balance controller.
- periph_rst_n  output  1  active-low reset to the SPI/inertial-sensor domain.
- ctrl_rst_n  output  1  active-low reset to the balance controller.
- pwr_en  output  1  motor drive enable.
- fault_code  output  2  fault cause: 0 none, 1 ready timeout, 2 external, 3 watchdog.

Function
REQ-003 The FSM SHALL have states HOLD, WAIT_READY, CTRL_DLY, RUN and FAULT.
REQ-004 HOLD: load the timer with PERIPH_DLY; after PERIPH_DLY clocks with RST_n high, set periph_rst_n=1 and go to WAIT_READY.
REQ-005 WAIT_READY: load READY_TO on entry; sensor_rdy=1 goes to CTRL_DLY; timer expiry goes to FAULT with fault_code=1; if both occur in the same cycle, sensor_rdy wins.
REQ-006 CTRL_DLY: after CTRL_DLY clocks, set ctrl_rst_n=1 and go to RUN.
REQ-007 RUN: pwr_en=1 the cycle after entry; sensor_rdy falling SHALL go to FAULT with fault_code=1.
REQ-008 fault_in=1 in WAIT_READY, CTRL_DLY or RUN SHALL go to FAULT with fault_code=2 on the next edge; fault_in takes priority over every other transition.
REQ-009 FAULT SHALL drive pwr_en=0 and ctrl_rst_n=0, and hold periph_rst_n=1.
REQ-010 FAULT SHALL exit only when clr_fault=1 and fault_in=0 in the same cycle; exit clears fault_code to 0 and goes to WAIT_READY.
REQ-011 clr_fault together with fault_in=1 SHALL be ignored; clr_fault outside FAULT SHALL be ignored.
REQ-012 All outputs SHALL be registered; no combinational path from input to output.
REQ-013 Timer width SHALL be the $clog2 of the largest delay parameter plus 1; a zero delay SHALL be treated as 1 clock.

Reset
REQ-014 RST_n low SHALL asynchronously force state HOLD, periph_rst_n=0, ctrl_rst_n=0, pwr_en=0, fault_code=0 and timer=PERIPH_DLY.
REQ-015 RST_n asserted mid-sequence, including in RUN or FAULT, SHALL abort the sequence immediately and restart from HOLD on release.

Configuration
REQ-016 Macro RST_SEQ_WDOG_EN SHALL control the watchdog:
- Defined: RUN reloads a WDOG_TO counter on each wdog_kick; expiry goes to FAULT with fault_code=3; wdog_kick on the expiry cycle prevents the fault.
- Undefined: wdog_kick is ignored, no watchdog logic is present, and fault_code never equals 3.

Structure
REQ-017 Package rst_seq_pkg SHALL hold:
- the state enum;
- the fault_code enum (FLT_NONE, FLT_RDY_TO, FLT_EXT, FLT_WDOG);
- the default delay constants.
REQ-018 Sub-module rst_seq_timer SHALL be a loadable down-counter with load, value and done ports, instanced once for sequencing and once more under RST_SEQ_WDOG_EN.

Verification
REQ-019 The bench SHALL use PERIPH_DLY=4, CTRL_DLY=2, READY_TO=10 and WDOG_TO=8, and SHALL cover:
- Nominal: RST_n released, sensor_rdy raised 3 clocks after periph_rst_n -> periph_rst_n high 4 clocks after release; ctrl_rst_n high 2 clocks after sensor_rdy; pwr_en high 1 clock later.
- Ready timeout: sensor_rdy held 0 -> FAULT 10 clocks after periph_rst_n rises, fault_code=1, ctrl_rst_n=0.
- External fault in RUN: fault_in pulse -> pwr_en=0 next edge, fault_code=2; clr_fault with fault_in=1 -> stays in FAULT; clr_fault with fault_in=0 -> WAIT_READY, fault_code=0.
- Mid-operation reset: RST_n low in RUN -> all outputs 0 asynchronously before the next edge; the full sequence repeats on release.
- Boundary: sensor_rdy rises on the same cycle the ready timer expires -> CTRL_DLY, no fault.
- Watchdog, with RST_SEQ_WDOG_EN defined: kicks every 7 clocks -> stays in RUN; kicks stopped -> fault_code=3 after 8 clocks. With the macro undefined -> no fault.
